// File: rtl/population_count_accumulator.sv
// Packet popcount accumulator: sums per-word popcounts over a valid/ready packet and
// presents total + word count. Optional macro POPCOUNT_SATURATE_EN clamps on overflow.

module population_count_combinational #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CNT_WIDTH-1:0]  count_o
);
  always_comb begin
    count_o = '0;
    for (int i = 0; i < DATA_WIDTH; i++) count_o = count_o + CNT_WIDTH'(data_i[i]);
  end
endmodule

module population_count_accumulator #(
  parameter int DATA_WIDTH     = 32,
  parameter int ACC_WIDTH      = 16,
  parameter int WORD_CNT_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  input  logic                      valid_i,
  input  logic                      last_i,
  output logic                      ready_o,
  output logic [ACC_WIDTH-1:0]      count_o,
  output logic [WORD_CNT_WIDTH-1:0] words_o,
  output logic                      overflow_o,
  output logic                      valid_o,
  input  logic                      ready_i
);
  localparam int PC_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  state_t                    state_q, state_d;
  logic [ACC_WIDTH-1:0]      acc_q, acc_d;
  logic [WORD_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic                      ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0]      count_q, count_d;
  logic [WORD_CNT_WIDTH-1:0] words_q, words_d;
  logic                      ovf_out_q, ovf_out_d;

  logic [PC_W-1:0]      pc;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;

  population_count_combinational #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(PC_W)) u_pc (
    .data_i  (data_i),
    .count_o (pc)
  );

  // One spare bit above the accumulator catches the carry for overflow detection.
  assign sum   = {1'b0, acc_q} + {{(ACC_WIDTH+1-PC_W){1'b0}}, pc};
  assign carry = sum[ACC_WIDTH];

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    word_cnt_d = word_cnt_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    words_d    = words_q;
    ovf_out_d  = ovf_out_q;
    case (state_q)
      ST_ACC: begin
        if (valid_i) begin
          word_cnt_d = word_cnt_q + WORD_CNT_WIDTH'(1);
          ovf_d      = ovf_q | carry;
`ifdef POPCOUNT_SATURATE_EN
          acc_d      = (ovf_q | carry) ? '1 : sum[ACC_WIDTH-1:0];
`else
          acc_d      = sum[ACC_WIDTH-1:0];
`endif
          if (last_i) begin
            state_d   = ST_OUT;
            count_d   = acc_d;
            words_d   = word_cnt_d;
            ovf_out_d = ovf_d;
          end
        end
      end
      ST_OUT: begin
        // Result registers keep the last packet after the handshake; only the
        // running state is cleared for the next packet.
        if (ready_i) begin
          state_d    = ST_ACC;
          acc_d      = '0;
          word_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      words_q    <= '0;
      ovf_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      words_q    <= words_d;
      ovf_out_q  <= ovf_out_d;
    end
  end

  assign ready_o    = (state_q == ST_ACC);
  assign valid_o    = (state_q == ST_OUT);
  assign count_o    = count_q;
  assign words_o    = words_q;
  assign overflow_o = ovf_out_q;
endmodule

// File: tb/tb_population_count_accumulator.sv
// Bench: two accumulators (16-bit and 6-bit totals) share one stimulus stream and are
// checked against a packet-level arithmetic model.
module tb_population_count_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic        valid = 1'b0, last = 1'b0, ready_i = 1'b0;

  logic        ready16, valid16, ovf16;
  logic [15:0] count16;
  logic [7:0]  words16;
  logic        ready6, valid6, ovf6;
  logic [5:0]  count6;
  logic [7:0]  words6;

  int checks = 0, errors = 0;
  int total = 0, nwords = 0;
  int e_tot = 0, e_words = 0;

  always #5 clk = ~clk;

  population_count_accumulator #(.DATA_WIDTH(32), .ACC_WIDTH(16), .WORD_CNT_WIDTH(8)) dut16 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid), .last_i(last),
    .ready_o(ready16), .count_o(count16), .words_o(words16), .overflow_o(ovf16),
    .valid_o(valid16), .ready_i(ready_i));

  population_count_accumulator #(.DATA_WIDTH(32), .ACC_WIDTH(6), .WORD_CNT_WIDTH(8)) dut6 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid), .last_i(last),
    .ready_o(ready6), .count_o(count6), .words_o(words6), .overflow_o(ovf6),
    .valid_o(valid6), .ready_i(ready_i));

  // Packet total as seen through a w-bit accumulator.
  function automatic int model_count(input int tot, input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef POPCOUNT_SATURATE_EN
    return (tot > mx) ? mx : tot;
`else
    return tot & mx;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid16"}, 32'(valid16), 32'd1);
    chk({tag, "_valid6"},  32'(valid6),  32'd1);
    chk({tag, "_ready16"}, 32'(ready16), 32'd0);
    chk({tag, "_count16"}, 32'(count16), 32'(model_count(e_tot, 16)));
    chk({tag, "_ovf16"},   32'(ovf16),   32'(e_tot > 65535));
    chk({tag, "_words16"}, 32'(words16), 32'(e_words % 256));
    chk({tag, "_count6"},  32'(count6),  32'(model_count(e_tot, 6)));
    chk({tag, "_ovf6"},    32'(ovf6),    32'(e_tot > 63));
    chk({tag, "_words6"},  32'(words6),  32'(e_words % 256));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; last = 1'b0;
    total = 0; nwords = 0;
    #1;
    chk({tag, "_ready16"}, 32'(ready16), 32'd1);
    chk({tag, "_ready6"},  32'(ready6),  32'd1);
    chk({tag, "_valid16"}, 32'(valid16), 32'd0);
    chk({tag, "_count16"}, 32'(count16), 32'd0);
    chk({tag, "_words16"}, 32'(words16), 32'd0);
    chk({tag, "_ovf16"},   32'(ovf16),   32'd0);
    chk({tag, "_count6"},  32'(count6),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one word after 'gap' idle cycles; hold it until accepted.
  task automatic beat(input logic [31:0] d, input logic l, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    data = d; valid = 1'b1; last = l;
    while (ready16 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(ready16), 32'd1);
    @(posedge clk);
    total += $countones(d);
    nwords++;
    #1;
    valid = 1'b0; last = 1'b0;
    if (l) begin
      e_tot = total; e_words = nwords;
      total = 0; nwords = 0;
      check_outputs("result");
    end else begin
      chk("mid_ready", 32'(ready16), 32'd1);
    end
  endtask

  // Stall the consumer, offering a bogus beat that must not be taken, then accept.
  task automatic get_result(input int stall);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      data = 32'hFFFF_FFFF; valid = 1'b1; last = 1'b1;
      check_outputs("hold");
    end
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0; last = 1'b0;
    chk("post_ready16", 32'(ready16), 32'd1);
    chk("post_ready6",  32'(ready6),  32'd1);
    chk("post_valid16", 32'(valid16), 32'd0);
    chk("post_valid6",  32'(valid6),  32'd0);
    ready_i = 1'b0;
  endtask

  initial begin
    do_reset("reset");

    // Directed three-word packet with 5 cycles of backpressure: total 38.
    beat(32'hFFFF_FFFF, 1'b0, 0);
    beat(32'h0000_000F, 1'b0, 0);
    beat(32'h8000_0001, 1'b1, 0);
    chk("directed_total", 32'(count16), 32'd38);
    get_result(5);

    // Single-word packet.
    beat(32'hA5A5_A5A5, 1'b1, 1);
    chk("single_total", 32'(count16), 32'd16);
    get_result(1);

    // Idle gaps inside a packet.
    beat(32'h0000_00FF, 1'b0, 0);
    beat(32'h0F00_0000, 1'b1, 3);
    get_result(0);

    // 64 ones: the 6-bit instance overflows.
    beat(32'hFFFF_FFFF, 1'b0, 0);
    beat(32'hFFFF_FFFF, 1'b1, 0);
    chk("ovf6_flag", 32'(ovf6), 32'd1);
    get_result(2);

    // Reset mid-packet, then a fresh packet counts from zero.
    beat(32'hFFFF_FFFF, 1'b0, 0);
    beat(32'hFFFF_FFFF, 1'b0, 0);
    do_reset("rst_mid");
    beat(32'h0000_0003, 1'b1, 0);
    chk("after_rst_total", 32'(count16), 32'd2);
    get_result(0);

    // Reset while holding a result.
    beat(32'h1234_5678, 1'b1, 0);
    do_reset("rst_out");

    // Back-to-back packets with the consumer always ready.
    ready_i = 1'b1;
    beat(32'hF0F0_F0F0, 1'b0, 0);
    beat(32'h0000_0001, 1'b1, 0);
    beat(32'h0000_0007, 1'b0, 0);
    beat(32'h0000_0003, 1'b1, 0);
    chk("b2b_second", 32'(count16), 32'd5);
    get_result(0);

    // Randomized packets.
    for (int p = 0; p < 20; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int w = 0; w < len; w++)
        beat(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
             (w == len - 1), $urandom_range(0, 2));
      get_result($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
